tx_byte_serializer: RTL

TX_BYTE_SERIALIZER -- requirements
Module: tx_byte_serializer

---
 rtl/tx_byte_serializer.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/tx_byte_serializer.sv
// ---------------------------------------------------------------------------
// tx_byte_serializer
//   Turns 32-bit big-endian frame words from the packet builder into a byte
//   stream for the MAC. Frames shorter than MIN_FRAME bytes are padded with
//   0x00 bytes, and frame_count counts the frames that completed.
//
// Ports
//   clk, rst          : clock (rising edge) and asynchronous active-high reset
//   word_in/_valid    : input frame word (bits 31:24 go out first) and valid
//   word_last         : word is the final word of its frame
//   word_bytes        : valid bytes in the final word (0 means 4)
//   word_ready        : a word is accepted this cycle (input FIFO not full)
//   tx_data/_valid    : byte towards the MAC and its valid
//   tx_sop/_eop       : first / last byte of a frame
//   tx_ready          : MAC accepts the byte
//   frame_count       : completed frames, wrapping at 16 bits
// ---------------------------------------------------------------------------
module tx_byte_serializer #(
  parameter int FIFO_DEPTH = 4,
  parameter int MIN_FRAME  = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] word_in,
  input  logic        word_valid,
  input  logic        word_last,
  input  logic [1:0]  word_bytes,
  output logic        word_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        tx_sop,
  output logic        tx_eop,
  input  logic        tx_ready,
  output logic [15:0] frame_count
);

  localparam int          AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [11:0] MIN_C   = 12'(MIN_FRAME);

  typedef enum logic [1:0] {IDLE, SEND, PAD} state_e;

  typedef struct packed {
    logic        last;
    logic [1:0]  bytes;
    logic [31:0] data;
  } entry_t;

  // Input FIFO
  entry_t          mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     count_q;

  // Active word and frame state
  state_e          state_q;
  logic [31:0]     act_word_q;
  logic            act_vld_q;
  logic            act_last_q;
  logic [1:0]      idx_q;
  logic [1:0]      last_idx_q;
  logic [10:0]     cnt_q;
  logic [15:0]     frame_cnt_q;

  entry_t          head;
  entry_t          in_entry;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            hs;
  logic            word_end;
  logic            long_enough;
  logic            send_eop;
  logic            pad_eop;
  logic            eop_hs;

  // Byte counter saturates so very long frames cannot wrap back to "byte 0".
  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  // Index of the last valid byte in a word; bytes-1 wraps 0 to 3 (four bytes).
  function automatic logic [1:0] last_idx_of(input entry_t e);
    return e.last ? (e.bytes - 2'd1) : 2'd3;
  endfunction

  always_comb begin
    head        = mem_q[rd_ptr_q];
    in_entry    = '{last: word_last, bytes: word_bytes, data: word_in};
    full        = (count_q == DEPTH_C);
    empty       = (count_q == '0);
    // Held low during reset; depends only on FIFO occupancy otherwise.
    word_ready  = ~full & ~rst;
    push        = word_valid & word_ready;

    tx_valid    = (state_q == PAD) | ((state_q == SEND) & act_vld_q);
    hs          = tx_valid & tx_ready;
    word_end    = (idx_q == last_idx_q);
    long_enough = (({1'b0, cnt_q}) + 12'd1) >= MIN_C;
    send_eop    = (state_q == SEND) & act_vld_q & word_end & act_last_q & long_enough;
    pad_eop     = (state_q == PAD) & long_enough;
    tx_eop      = send_eop | pad_eop;
    eop_hs      = hs & tx_eop;
    tx_sop      = tx_valid & (cnt_q == '0);

    tx_data = 8'h00;
    if ((state_q == SEND) && act_vld_q) begin
      case (idx_q)
        2'd0:    tx_data = act_word_q[31:24];
        2'd1:    tx_data = act_word_q[23:16];
        2'd2:    tx_data = act_word_q[15:8];
        default: tx_data = act_word_q[7:0];
      endcase
    end

    // The FIFO head becomes the active word whenever the active slot frees up:
    // at start of frame, after an underrun bubble, after the last byte of a
    // non-final word, or right at an eop so frames run back to back.
    pop = 1'b0;
    case (state_q)
      IDLE: pop = ~empty;
      SEND: begin
        if (!act_vld_q)
          pop = ~empty;
        else if (hs && word_end)
          pop = ~empty & (~act_last_q | send_eop);
      end
      PAD:  pop = eop_hs & ~empty;
      default: pop = 1'b0;
    endcase
  end

  assign frame_count = frame_cnt_q;

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= in_entry;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
      act_word_q  <= '0;
      act_vld_q   <= 1'b0;
      act_last_q  <= 1'b0;
      idx_q       <= '0;
      last_idx_q  <= '0;
      cnt_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase

      if (eop_hs) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (hs)     cnt_q       <= sat_inc(cnt_q);
      if (hs && !word_end && (state_q == SEND))
        idx_q <= idx_q + 2'd1;

      if (pop) begin
        act_word_q <= head.data;
        act_last_q <= head.last;
        last_idx_q <= last_idx_of(head);
        idx_q      <= '0;
        act_vld_q  <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (pop) begin
            cnt_q   <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (hs && word_end) begin
            if (send_eop) begin
              if (pop) begin
                cnt_q <= '0;
              end else begin
                state_q   <= IDLE;
                act_vld_q <= 1'b0;
              end
            end else if (act_last_q) begin
              // Last data byte of a short frame: pad out to MIN_FRAME.
              state_q   <= PAD;
              act_vld_q <= 1'b0;
            end else if (!pop) begin
              // Underrun bubble until the next word shows up.
              act_vld_q <= 1'b0;
            end
          end
        end
        PAD: begin
          if (eop_hs) begin
            if (pop) begin
              cnt_q   <= '0;
              state_q <= SEND;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
